// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX stage (master) and the divider (slave).
// Suffixes mark direction as seen from the divider.
interface div_unit_if #(
  parameter int DIV_W = 32
);
  logic               start_i;
  logic               signed_i;
  logic               annul_i;
  logic [DIV_W-1:0]   dividend_i;
  logic [DIV_W-1:0]   divisor_i;
  logic [2*DIV_W-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, dividend_i, divisor_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: 32 iterations, sign fix-up on the last edge.
// result_o = {remainder, quotient}, valid only while ready_o is high.
module div_unit #(
  parameter int DIV_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BYZERO, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q;
  logic [2*DIV_W:0]   work_q, work_d;   // {partial remainder (33b), quotient (32b)}
  logic [DIV_W-1:0]   dvd_q, dsr_q;
  logic               dvd_neg_q, dsr_neg_q, signed_q;
  logic [2*DIV_W-1:0] result_q, result_d;
  logic               accept, step, last_step;

  logic [DIV_W+1:0]   rem_sh, diff;
  logic [DIV_W-1:0]   dvd_abs, dsr_abs, quo_abs, rem_abs, quo_fin, rem_fin;

  assign dvd_abs = (bus.signed_i && bus.dividend_i[DIV_W-1]) ? -bus.dividend_i : bus.dividend_i;
  assign dsr_abs = (bus.signed_i && bus.divisor_i[DIV_W-1])  ? -bus.divisor_i  : bus.divisor_i;
  assign last_step = (cnt_q == 6'(DIV_W - 1));

  // One restoring step: the top bit of the difference is the borrow that rejects the trial.
  always_comb begin
    rem_sh = {work_q[2*DIV_W:DIV_W], dvd_q[DIV_W-1]};
    diff   = rem_sh - {2'b00, dsr_q};
    if (diff[DIV_W+1]) work_d = {rem_sh[DIV_W:0], work_q[DIV_W-2:0], 1'b0};
    else               work_d = {diff[DIV_W:0],   work_q[DIV_W-2:0], 1'b1};
    quo_abs = work_d[DIV_W-1:0];
    rem_abs = work_d[2*DIV_W-1:DIV_W];
    quo_fin = (signed_q && (dvd_neg_q ^ dsr_neg_q)) ? -quo_abs : quo_abs;
    rem_fin = (signed_q && dvd_neg_q) ? -rem_abs : rem_abs;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    result_d = '0;
    accept   = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.divisor_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = BUSY;
            accept  = 1'b1;
          end
        end
      end
      BYZERO: state_d = DONE;
      BUSY: begin
        step = 1'b1;
        if (last_step) begin
          state_d  = DONE;
          result_d = {rem_fin, quo_fin};
        end
      end
      DONE: begin
        if (bus.start_i) result_d = result_q;
        else             state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush beats everything else, including a completing step.
    if (bus.annul_i) begin
      state_d  = IDLE;
      result_d = '0;
      accept   = 1'b0;
      step     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so an abandoned operation leaves no residue behind.
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      dvd_neg_q <= 1'b0;
      dsr_neg_q <= 1'b0;
      signed_q  <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      work_q    <= '0;
      dvd_q     <= dvd_abs;
      dsr_q     <= dsr_abs;
      dvd_neg_q <= bus.dividend_i[DIV_W-1];
      dsr_neg_q <= bus.divisor_i[DIV_W-1];
      signed_q  <= bus.signed_i;
    end else if (step) begin
      cnt_q  <= cnt_q + 6'd1;
      work_q <= work_d;
      dvd_q  <= dvd_q << 1;
    end
  end

  assign bus.ready_o    = (state_q == DONE);
  assign bus.result_o   = result_q;
  assign bus.stallreq_o = bus.start_i & ~bus.ready_o & ~bus.annul_i;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model plus a per-cycle compare process.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;

  div_unit_if #(.DIV_W(32)) bus();
  div_unit #(.DIV_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ready_at = 0;
  int          stall_cnt = 0;
  bit          txn_active = 1'b0;
  bit          chk_en = 1'b0;
  bit          exp_rdy;
  logic [63:0] exp_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, remainder takes the dividend's sign, /0 gives 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Expected outputs follow from the transaction window alone: ready after the
  // 33rd edge (2nd for divisor 0), result only while ready.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_rdy = txn_active && (cyc >= ready_at);
      check("ready_o", 64'(bus.ready_o), 64'(exp_rdy));
      check("result_o", bus.result_o, exp_rdy ? exp_res : 64'h0);
      check("stallreq_o", 64'(bus.stallreq_o), 64'(bus.start_i & ~exp_rdy & ~bus.annul_i));
      if (bus.stallreq_o) stall_cnt++;
    end
  end

  // Raise start and run until ready (abort_at=0) or for abort_at edges; operands are scrambled after acceptance.
  task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int abort_at);
    int start_cyc;
    start_cyc      = cyc;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    exp_res        = model(a, b, sgn);
    ready_at       = cyc + ((b == 32'h0) ? 2 : 33);
    txn_active     = 1'b1;
    @(posedge clk); #1;
    while (cyc < ready_at && (abort_at == 0 || cyc < start_cyc + abort_at)) begin
      bus.dividend_i = $urandom;
      bus.divisor_i  = $urandom;
      bus.signed_i   = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic end_op(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    txn_active = 1'b0;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] lit);
    check({name, "_model"}, model(a, b, sgn), lit);
    stall_cnt = 0;
    begin_op(a, b, sgn, 0);
    check(name, bus.result_o, lit);
    check({name, "_stall_cycles"}, 64'(stall_cnt), (b == 32'h0) ? 64'd2 : 64'd33);
    end_op(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.annul_i    = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;

    @(posedge clk); #1;
    check("rst_ready", 64'(bus.ready_o), 64'h0);
    check("rst_result", bus.result_o, 64'h0);
    check("rst_stall_low", 64'(bus.stallreq_o), 64'h0);
    bus.start_i = 1'b1;
    #1;
    check("rst_stall_follows_start", 64'(bus.stallreq_o), 64'h1);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    check("pin_model_neg_div", model(32'hFFFF_FFF0, 32'h3, 1'b1), 64'hFFFF_FFFF_FFFF_FFFB);
    check("pin_model_udiv", model(32'd1000, 32'd33, 1'b0), 64'h0000_000A_0000_001E);

    directed("u_7_2",       32'd7,          32'd2,          1'b0, 64'h0000_0001_0000_0003);
    directed("s_m7_2",      32'hFFFF_FFF9,  32'h2,          1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    directed("s_7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1, 64'h0000_0001_FFFF_FFFD);
    directed("by_zero",     32'h1234,       32'h0,          1'b0, 64'h0);
    directed("s_min_m1",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_8000_0000);
    directed("u_max_1",     32'hFFFF_FFFF,  32'h1,          1'b0, 64'h0000_0000_FFFF_FFFF);
    directed("u_min_max",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 64'h8000_0000_0000_0000);

    // Flush in the middle of the iteration, then a clean operation.
    begin_op(32'd1000, 32'd3, 1'b0, 10);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    txn_active  = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check("annul_no_ready", 64'(bus.ready_o), 64'h0);
    directed("u_100_7", 32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E);

    // Asynchronous reset while busy.
    begin_op(32'd50, 32'd3, 1'b0, 6);
    rst        = 1'b1;
    txn_active = 1'b0;
    #1;
    check("rst_busy_ready", 64'(bus.ready_o), 64'h0);
    check("rst_busy_result", bus.result_o, 64'h0);
    check("rst_busy_stall", 64'(bus.stallreq_o), 64'h1);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    directed("u_9_3", 32'd9, 32'd3, 1'b0, 64'h0000_0000_0000_0003);

    // Asynchronous reset while a result is being held.
    begin_op(32'hFFFF, 32'h10, 1'b0, 0);
    check("done_before_rst", bus.result_o, 64'h0000_000F_0000_0FFF);
    rst        = 1'b1;
    txn_active = 1'b0;
    #1;
    check("rst_done_ready", 64'(bus.ready_o), 64'h0);
    check("rst_done_result", bus.result_o, 64'h0);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    directed("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 64'hFFFF_FFFE_FFFF_FFF2);

    for (int i = 0; i < 40; i++) begin
      a = (i % 9 == 4) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1, 2, 3: b = $urandom_range(1, 15);
        4:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      begin_op(a, b, 1'($urandom), 0);
      end_op($urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DIV_W, default 32, operand width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  EX stage requests a divide; held high until ready_o is seen.
REQ-005 signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 annul_i  input  1  cancel any operation in flight (flush or exception).
REQ-007 dividend_i  input  32  rs operand.
REQ-008 divisor_i  input  32  rt operand.
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}, registered.
REQ-010 ready_o  output  1  result_o is valid this cycle.
REQ-011 stallreq_o  output  1  request to freeze the IF, ID and EX stages, combinational.

Function
REQ-012 The FSM SHALL have four states: IDLE, BYZERO, BUSY and DONE.
REQ-013 IDLE, start_i=1, annul_i=0, divisor_i=0 -> BYZERO.
REQ-014 IDLE, start_i=1, annul_i=0, divisor_i!=0 -> BUSY; on the same edge the unit SHALL latch |dividend|, |divisor| (magnitudes only when signed_i=1), the two sign bits and signed_i, and SHALL clear the 6-bit iteration counter and the 65-bit partial remainder/quotient register.
REQ-015 Operand changes after acceptance SHALL have no effect.
REQ-016 BUSY SHALL perform one restoring-division step per edge: shift left 1, trial-subtract the divisor from the upper 33 bits, keep the difference if it is non-negative, shift in the quotient bit, and increment the counter.
REQ-017 The edge that completes step 32 SHALL move BUSY -> DONE and load result_o.
REQ-018 Signed correction on that edge: quotient negated iff the dividend and divisor signs differ; remainder negated iff the dividend is negative.
REQ-019 Widths: quotient and remainder are truncated to 32 bits; 0x80000000 / -1 signed gives quotient 0x80000000, remainder 0, with no exception.
REQ-020 BYZERO SHALL go to DONE on the next edge with result_o = 64'h0.
REQ-021 DONE: ready_o=1 and result_o is held stable; start_i=0 -> IDLE next edge; start_i=1 -> remain in DONE.
REQ-022 Latency: ready_o SHALL assert after the 33rd edge counting the accepting edge as the 1st (divisor 0: after the 2nd edge).
REQ-023 ready_o SHALL be 0 in IDLE, BYZERO and BUSY.
REQ-024 result_o SHALL be 0 except in DONE.
REQ-025 stallreq_o SHALL equal start_i & ~ready_o & ~annul_i.
REQ-026 annul_i=1 in any state SHALL force IDLE on the next edge, with ready_o=0 and result_o=0; annul_i wins over start_i on the same edge.
REQ-027 start_i=1 in BUSY or BYZERO SHALL be ignored; there is no re-start until IDLE.
REQ-028 The downstream HI/LO write path SHALL use only result_o captured while ready_o=1.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force: state=IDLE, counter=0, datapath registers=0, result_o=0, ready_o=0.
REQ-030 While rst=1, stallreq_o SHALL still follow REQ-025, i.e. equal start_i.
REQ-031 Reset asserted mid-BUSY SHALL abandon the operation.
REQ-032 After rst deasserts, the first start_i edge SHALL be accepted normally.

Verification
REQ-033 Unsigned 7/2, start held high: stallreq_o=1 for 33 cycles, then ready_o=1 with result_o=64'h00000001_00000003; start_i dropped -> IDLE next edge.
REQ-034 Signed -7/2 (0xFFFFFFF9, 0x2): result_o = 64'hFFFFFFFF_FFFFFFFD; signed 7/-2: 64'h00000001_FFFFFFFD.
REQ-035 Divisor 0, dividend 0x1234: ready_o=1 after the 2nd edge, result_o=0; stallreq_o high for exactly 2 cycles.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000; unsigned 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
REQ-037 annul_i pulsed at BUSY step 10 -> IDLE next edge, ready_o never asserts; a new 100/7 started afterwards -> 64'h00000002_0000000E.
REQ-038 rst asserted asynchronously mid-BUSY -> outputs 0 before the next clk edge; a subsequent 9/3 -> 64'h00000000_00000003.
